// File: rtl/simon_pkg.sv
// Shared SIMON constants, helpers and the key-unroll state type.
package simon_pkg;

   localparam int SIMON64_96_N = 32;
   localparam int SIMON64_96_T = 42;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } key_unroll_state_t;

   function automatic logic [61:0] rev62(input logic [61:0] s);
      logic [61:0] r;
      for (int i = 0; i < 62; i++) begin
         r[i] = s[61-i];
      end
      return r;
   endfunction

   // Literals are written in publication order; stored so that bit k = z[k].
   localparam logic [61:0] Z0 = rev62(62'b11111010001001010110000111001101111101000100101011000011100110);
   localparam logic [61:0] Z1 = rev62(62'b10001110111110010011000010110101000111011111001001100001011010);
   localparam logic [61:0] Z2 = rev62(62'b10101111011100000011010010011000101000010001111110010110110011);
   localparam logic [61:0] Z3 = rev62(62'b11011011101011000110010111100000010010001010011100110100001111);
   localparam logic [61:0] Z4 = rev62(62'b11010001111001101011011000100000010111000011001010010011101111);

   function automatic logic [63:0] key_const(input int unsigned n);
      return (64'd1 << n) - 64'd4;
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] word, input int unsigned amount,
                                       input int unsigned width);
      logic [63:0] r;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < width) begin
            r[i] = word[(i + amount) % width];
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/simon_key_step_inv.sv
// Combinational inverse of one SIMON (M=3) key-schedule step: recovers rk[i-3].
module simon_key_step_inv
   import simon_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] rk_i,
   input  logic [N-1:0] rk_im1,
   input  logic         z_bit,
   output logic [N-1:0] rk_im3
);

   logic [63:0] c_s;
   logic [63:0] r3_s;
   logic [63:0] r4_s;

   assign c_s  = key_const(N);
   assign r3_s = ror(64'(rk_im1), 3, N);
   assign r4_s = ror(64'(rk_im1), 4, N);

   assign rk_im3 = rk_i ^ c_s[N-1:0] ^ {{(N-1){1'b0}}, z_bit} ^ r3_s[N-1:0] ^ r4_s[N-1:0];

endmodule

// File: rtl/simon_key_unroll_chk.sv
// Elaboration-time parameter checks for simon_key_unroll.
module simon_key_unroll_chk #(
   parameter int M = 3,
   parameter int T = 42
) ();

   if (M != 3 || T < 4 || T > 62) begin : g_bad_params
      $fatal(1, "simon_key_unroll: requires M == 3 and 4 <= T <= 62");
   end

endmodule

// File: rtl/simon_key_unroll.sv
// Streams SIMON round keys rk[T-1]..rk[0] by running the key recurrence backwards.
// Optional self-check against the master key: define SIMON_KEY_UNROLL_CHECK_EN.
module simon_key_unroll
   import simon_pkg::*;
#(
   parameter int          N     = SIMON64_96_N,
   parameter int          M     = 3,
   parameter int          T     = SIMON64_96_T,
   parameter logic [61:0] Z_SEQ = Z2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_valid,
   output logic           load_ready,
   input  logic [3*N-1:0] last_keys,
   output logic           rk_valid,
   input  logic           rk_ready,
   output logic [N-1:0]   rk_data,
   output logic [5:0]     rk_index,
   output logic           rk_last,
   output logic           busy
`ifdef SIMON_KEY_UNROLL_CHECK_EN
   ,
   input  logic [3*N-1:0] master_key,
   output logic           chk_done,
   output logic           chk_fail
`endif
);

   key_unroll_state_t state_q, state_d;
   logic [N-1:0] w2_q, w2_d, w1_q, w1_d, w0_q, w0_d;
   logic [5:0]   idx_q, idx_d, zc_q, zc_d;
   logic         load_ready_q, load_ready_d;
   logic         rk_valid_q, rk_valid_d;
   logic         rk_last_q, rk_last_d;
   logic         busy_q, busy_d;
   logic [N-1:0] w0_next_s;
   logic         hs_s, ld_s;

   simon_key_unroll_chk #(.M(M), .T(T)) u_param_chk ();

   simon_key_step_inv #(.N(N)) u_step (
      .rk_i   (w2_q),
      .rk_im1 (w1_q),
      .z_bit  (Z_SEQ[zc_q]),
      .rk_im3 (w0_next_s)
   );

   assign hs_s = rk_valid_q && rk_ready;
   assign ld_s = load_valid && load_ready_q;

   // Window shift and next-state; the window is w2=rk[idx], w1=rk[idx-1], w0=rk[idx-2].
   always_comb begin
      state_d = state_q;
      w2_d    = w2_q;
      w1_d    = w1_q;
      w0_d    = w0_q;
      idx_d   = idx_q;
      zc_d    = zc_q;
      case (state_q)
         IDLE: begin
            if (ld_s) begin
               w2_d    = last_keys[3*N-1:2*N];
               w1_d    = last_keys[2*N-1:N];
               w0_d    = last_keys[N-1:0];
               idx_d   = 6'(T - 1);
               zc_d    = 6'(T - 4);
               state_d = EMIT;
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (hs_s) begin
               if (idx_q == 6'd0) begin
                  state_d = IDLE;
               end else begin
                  w2_d  = w1_q;
                  w1_d  = w0_q;
                  idx_d = idx_q - 6'd1;
                  if (idx_q >= 6'd3) begin
                     w0_d = w0_next_s;
                     zc_d = (zc_q == 6'd0) ? 6'd61 : (zc_q - 6'd1);
                  end else begin
                     w0_d = '0;
                  end
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      load_ready_d = (state_d == IDLE);
      rk_valid_d   = (state_d == EMIT);
      busy_d       = (state_d == EMIT);
      rk_last_d    = (state_d == EMIT) && (idx_d == 6'd0);
   end

   // State, window and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         w2_q         <= '0;
         w1_q         <= '0;
         w0_q         <= '0;
         idx_q        <= 6'd0;
         zc_q         <= 6'd0;
         load_ready_q <= 1'b1;
         rk_valid_q   <= 1'b0;
         rk_last_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         w2_q         <= w2_d;
         w1_q         <= w1_d;
         w0_q         <= w0_d;
         idx_q        <= idx_d;
         zc_q         <= zc_d;
         load_ready_q <= load_ready_d;
         rk_valid_q   <= rk_valid_d;
         rk_last_q    <= rk_last_d;
         busy_q       <= busy_d;
      end
   end

   assign load_ready = load_ready_q;
   assign rk_valid   = rk_valid_q;
   assign rk_data    = w2_q;
   assign rk_index   = idx_q;
   assign rk_last    = rk_last_q;
   assign busy       = busy_q;

`ifdef SIMON_KEY_UNROLL_CHECK_EN
   logic [3*N-1:0] mk_q, mk_d;
   logic           mis_q, mis_d;
   logic           chk_done_q, chk_done_d;
   logic           chk_fail_q, chk_fail_d;
   logic [N-1:0]   mk_word_s;
   logic           word_mis_s;

   // Recovered rk[0..2] must reproduce the captured master key words.
   always_comb begin
      case (idx_q[1:0])
         2'd2:    mk_word_s = mk_q[3*N-1:2*N];
         2'd1:    mk_word_s = mk_q[2*N-1:N];
         default: mk_word_s = mk_q[N-1:0];
      endcase
      word_mis_s = (w2_q != mk_word_s);
      mk_d       = mk_q;
      mis_d      = mis_q;
      chk_done_d = 1'b0;
      chk_fail_d = chk_fail_q;
      if (ld_s) begin
         mk_d       = master_key;
         mis_d      = 1'b0;
         chk_fail_d = 1'b0;
      end else if (hs_s && (idx_q <= 6'd2)) begin
         mis_d = mis_q | word_mis_s;
         if (idx_q == 6'd0) begin
            chk_done_d = 1'b1;
            chk_fail_d = mis_q | word_mis_s;
         end else begin
            chk_done_d = 1'b0;
         end
      end else begin
         mis_d = mis_q;
      end
   end

   // Check result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mk_q       <= '0;
         mis_q      <= 1'b0;
         chk_done_q <= 1'b0;
         chk_fail_q <= 1'b0;
      end else begin
         mk_q       <= mk_d;
         mis_q      <= mis_d;
         chk_done_q <= chk_done_d;
         chk_fail_q <= chk_fail_d;
      end
   end

   assign chk_done = chk_done_q;
   assign chk_fail = chk_fail_q;
`endif

endmodule

// File: tb/tb_simon_key_unroll.sv
// Self-checking bench for simon_key_unroll (SIMON64/96 reverse key schedule).
module tb_simon_key_unroll;

   localparam int N = 32;
   localparam int T = 42;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic [3*N-1:0] last_keys = '0;
   logic          rk_valid;
   logic          rk_ready = 1'b0;
   logic [N-1:0]  rk_data;
   logic [5:0]    rk_index;
   logic          rk_last;
   logic          busy;
   logic [3*N-1:0] master_key = '0;
`ifdef SIMON_KEY_UNROLL_CHECK_EN
   logic          chk_done;
   logic          chk_fail;
`endif

   int n_pass = 0;
   int n_total = 0;
   logic [N-1:0] g [0:T-1];
   logic [N-1:0] cur_k2, cur_k1, cur_k0;
   string z2s = "10101111011100000011010010011000101000010001111110010110110011";

   simon_key_unroll #(.N(N), .M(3), .T(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .last_keys  (last_keys),
      .rk_valid   (rk_valid),
      .rk_ready   (rk_ready),
      .rk_data    (rk_data),
      .rk_index   (rk_index),
      .rk_last    (rk_last),
      .busy       (busy)
`ifdef SIMON_KEY_UNROLL_CHECK_EN
      ,
      .master_key (master_key),
      .chk_done   (chk_done),
      .chk_fail   (chk_fail)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Forward reference key schedule in the published ~x ^ 3 form.
   task automatic gen(input logic [N-1:0] k2, input logic [N-1:0] k1, input logic [N-1:0] k0);
      logic [N-1:0] t;
      g[0] = k0; g[1] = k1; g[2] = k2;
      cur_k2 = k2; cur_k1 = k1; cur_k0 = k0;
      for (int i = 3; i < T; i++) begin
         t = {g[i-1][2:0], g[i-1][N-1:3]};
         t = t ^ {t[0], t[N-1:1]};
         g[i] = ~g[i-3] ^ t ^ 32'd3 ^ ((z2s[i-3] == 8'h31) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic do_load(input logic [N-1:0] k2, input logic [N-1:0] k1, input logic [N-1:0] k0,
                          input bit flip);
      int w;
      w = 0;
      gen(k2, k1, k0);
      @(negedge clk);
      while (load_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("load_ready_before_load", 64'(load_ready), 64'd1);
      last_keys  = {g[T-1], g[T-2], g[T-3]};
      master_key = {k2, k1, k0} ^ (flip ? 96'd1 : 96'd0);
      load_valid = 1'b1;
   endtask

   task automatic drain(input int pct, input bit hold, input bit exp_fail);
      int exp_idx, cyc;
      bit done;
      exp_idx = T - 1;
      cyc = 0;
      done = 1'b0;
      while (!done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (!hold) load_valid = 1'b0;
         check("rk_valid", 64'(rk_valid), 64'd1);
         check("rk_data", 64'(rk_data), 64'(g[exp_idx]));
         check("rk_index", 64'(rk_index), 64'(exp_idx));
         check("rk_last", 64'(rk_last), 64'(exp_idx == 0));
         check("load_ready_in_emit", 64'(load_ready), 64'd0);
         check("busy_in_emit", 64'(busy), 64'd1);
         if (exp_idx == 2) check("master_word2", 64'(rk_data), 64'(cur_k2));
         if (exp_idx == 1) check("master_word1", 64'(rk_data), 64'(cur_k1));
         if (exp_idx == 0) check("master_word0", 64'(rk_data), 64'(cur_k0));
         rk_ready = ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
         if (rk_ready) begin
            if (exp_idx == 0) done = 1'b1;
            else exp_idx--;
         end
      end
      if (!done) check("stream_timeout", 64'(exp_idx), 64'd0);
      if (pct >= 100) check("continuous_cycles", 64'(cyc), 64'(T));
      @(negedge clk);
      check("busy_after_last", 64'(busy), 64'd0);
      check("valid_after_last", 64'(rk_valid), 64'd0);
      check("load_ready_after_last", 64'(load_ready), 64'd1);
      check("rk_last_after_last", 64'(rk_last), 64'd0);
`ifdef SIMON_KEY_UNROLL_CHECK_EN
      check("chk_done", 64'(chk_done), 64'd1);
      check("chk_fail", 64'(chk_fail), 64'(exp_fail));
`else
      if (exp_fail) check("exp_fail_unused", 64'(exp_fail), 64'(exp_fail));
`endif
   endtask

   typedef struct {
      logic [N-1:0] k2, k1, k0;
      int           pct;
      bit           hold;
      bit           flip;
      bit           exp_fail;
   } vec_t;

   vec_t tbl [4];

   initial begin
      tbl[0] = '{32'h13121110, 32'h0b0a0908, 32'h03020100, 100, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{32'h13121110, 32'h0b0a0908, 32'h03020100, 50,  1'b0, 1'b0, 1'b0};
      tbl[2] = '{32'h13121110, 32'h0b0a0908, 32'h03020100, 100, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{32'hdeadbeef, 32'h01234567, 32'h89abcdef, 70,  1'b0, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check("reset_valid", 64'(rk_valid), 64'd0);
      check("reset_last", 64'(rk_last), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_load_ready", 64'(load_ready), 64'd1);
      check("reset_data", 64'(rk_data), 64'd0);
      check("reset_index", 64'(rk_index), 64'd0);
      rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         do_load(tbl[v].k2, tbl[v].k1, tbl[v].k0, tbl[v].flip);
         drain(tbl[v].pct, tbl[v].hold, tbl[v].exp_fail);
         if (tbl[v].hold) begin
            // load_valid still high: the same keys are taken right after rk_last.
            drain(100, 1'b0, tbl[v].exp_fail);
         end
      end

      // Asynchronous reset in the middle of a stream, then a clean restart.
      do_load(32'h13121110, 32'h0b0a0908, 32'h03020100, 1'b0);
      begin
         int w;
         w = 0;
         @(negedge clk);
         load_valid = 1'b0;
         rk_ready = 1'b1;
         while (rk_index !== 6'd20 && w < 100) begin
            @(negedge clk);
            w++;
         end
         check("reach_index20", 64'(rk_index), 64'd20);
         check("data_index20", 64'(rk_data), 64'(g[20]));
         rk_ready = 1'b0;
         rst = 1'b1;
         #1;
         check("midrst_valid", 64'(rk_valid), 64'd0);
         check("midrst_last", 64'(rk_last), 64'd0);
         check("midrst_busy", 64'(busy), 64'd0);
         check("midrst_load_ready", 64'(load_ready), 64'd1);
         check("midrst_data", 64'(rk_data), 64'd0);
         check("midrst_index", 64'(rk_index), 64'd0);
`ifdef SIMON_KEY_UNROLL_CHECK_EN
         check("midrst_chk_done", 64'(chk_done), 64'd0);
         check("midrst_chk_fail", 64'(chk_fail), 64'd0);
`endif
         @(negedge clk);
         rst = 1'b0;
      end
      do_load(32'h13121110, 32'h0b0a0908, 32'h03020100, 1'b0);
      drain(100, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/simon_key_unroll.md
Name: simon_key_unroll

Overview:
- Reverse key-schedule engine for SIMON decryption.
- Loaded with the final M round keys (rk[T-1]..rk[T-M]); streams all T round keys in descending index order, rk[T-1] down to rk[0], over a valid/ready interface.
- Runs the forward key recurrence backwards, one key per cycle, so the decrypt datapath never stores the full expanded schedule.
- Sits between key storage and the decrypt round pipeline.

Parameters:
- N, 32: word size in bits.
- M, 3: number of key words. Only 3 is supported.
- T, 42: total round keys. Must satisfy M+1 <= T <= 62.
- Z_SEQ, z2 (62'b bit-reversed so bit 0 = first z2 symbol "1010111101..."): constant sequence; bit k = z[k].

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- load_valid  in  1  last-keys word valid.
- load_ready  out  1  engine idle, will accept a load.
- last_keys  in  3N  bits [3N-1:2N] = rk[T-1], [2N-1:N] = rk[T-2], [N-1:0] = rk[T-3].
- rk_valid  out  1  round key output valid.
- rk_ready  in  1  consumer accepts the key.
- rk_data  out  N  round key.
- rk_index  out  6  index of rk_data (T-1 down to 0).
- rk_last  out  1  high with rk_index == 0.
- busy  out  1  high in EMIT state.

Behaviour:
- Reset (async, any time, including mid-stream):
  - state = IDLE; window registers w2/w1/w0 = 0; rk_index = 0; z counter = 0.
  - Outputs: rk_valid = 0, rk_last = 0, busy = 0, load_ready = 1, rk_data = 0.
  - Any in-flight stream is abandoned; no partial continuation after reset.
- IDLE:
  - load_ready = 1, rk_valid = 0.
  - On load_valid && load_ready:
    - w2 <= rk[T-1], w1 <= rk[T-2], w0 <= rk[T-3].
    - idx <= T-1; zc <= (T-4) mod 62.
    - Go to EMIT.
  - Latency: first rk_valid is the cycle after the load handshake.
- EMIT:
  - load_ready = 0; load_valid is ignored.
  - Outputs: rk_data = w2, rk_index = idx, rk_valid = 1 (all driven directly from registers).
  - If rk_ready is low, all outputs and state hold stable.
  - On rk_valid && rk_ready with idx > 0:
    - w2 <= w1, w1 <= w0, idx <= idx-1.
    - If idx >= 3: w0 <= w2 ^ C ^ {N-1 zeros, Z_SEQ[zc]} ^ ror(w1,3) ^ ror(w1,4), where C = 2^N - 4.
      - This inverts rk[i] = C ^ z ^ rk[i-3] ^ ror3(rk[i-1]) ^ ror4(rk[i-1]).
    - Otherwise w0 <= 0 (don't-care, never emitted).
    - zc decrements modulo 62 (0 wraps to 61) whenever a new w0 is computed.
  - On handshake with idx == 0 (rk_last = 1): go to IDLE next cycle.
- Throughput: one key per cycle under continuous rk_ready. A full stream is T handshakes.
- Arithmetic: all XOR; rotations are right-circular on N bits; no carries.
- Edge rules:
  - Back-to-back streams: a new load is accepted no earlier than the cycle after the rk_last handshake.
  - rk_ready may toggle arbitrarily; no key is dropped or duplicated.
- Elaboration assertion: M == 3 and T >= 4.

Optional Feature:
- Macro: SIMON_KEY_UNROLL_CHECK_EN.
- Defined:
  - Adds input master_key [3N-1:0], captured on the load handshake.
  - Adds outputs chk_done and chk_fail.
  - Each emitted rk[0..2] is compared against the matching captured word.
  - One cycle after the rk_last handshake: chk_done pulses 1 cycle, and chk_fail = 1 if any word mismatched. chk_fail holds until the next load or reset.
  - Both outputs reset to 0.
- Undefined: the extra ports and comparison logic are absent; behaviour is otherwise identical.

Decomposition:
- Package simon_pkg:
  - Z0..Z4 62-bit sequence constants.
  - Function key_const(N) returning 2^N - 4.
  - Function ror(word, amount).
  - Word-size and round-count localparams for 64/96.
  - Enum key_unroll_state_t {IDLE, EMIT}.
- Sub-module simon_key_step_inv: purely combinational inverse step.
  - Inputs: rk_i, rk_im1, z_bit.
  - Output: rk_im3.
  - Reusable by a future inverse-in-place key unit.

Test Plan:
- SIMON64/96 vector (master words 0x03020100, 0x0b0a0908, 0x13121110): golden forward model supplies rk[41..39] as the load. Stream with rk_ready = 1 gives 42 keys matching the golden model in reverse; indices 2, 1, 0 = 0x13121110, 0x0b0a0908, 0x03020100; rk_last only on index 0.
- Random rk_ready backpressure (~50%) on the same vector: identical key sequence, and rk_data/rk_index stay stable while rk_valid && !rk_ready.
- load_valid held high throughout EMIT: load_ready stays 0, the stream is unaffected, and the next load is accepted the cycle after rk_last.
- Async rst asserted at index 20: outputs are at reset values immediately; a fresh load then yields a full, correct 42-key stream.
- Continuous stream: the load handshake produces rk_valid on the next cycle and 42 consecutive handshake cycles; busy drops the cycle after rk_last.
- With SIMON_KEY_UNROLL_CHECK_EN defined:
  - Correct master_key: chk_done pulses with chk_fail = 0.
  - Master_key with bit 0 flipped: chk_fail = 1.
